// File: rtl/register_file_pkg.sv
// Shared register-file definitions used by decode, writeback and the register file itself.
package register_file_pkg;

  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned REG_DATA_WIDTH = 32;
  localparam int unsigned REG_COUNT      = 1 << REG_ADDR_WIDTH;

  // Index of the register that reads as zero when the zero-register option is enabled
  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;

  // One write-port request as seen by the writeback stage
  typedef struct packed {
    logic      en;
    reg_addr_t addr;
    reg_data_t data;
  } reg_wr_t;

endpackage

// File: rtl/register_file_if.sv
// Register-file access bus: two read address/data pairs and one write port.
interface register_file_if
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = REG_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH
);

  logic [ADDR_WIDTH-1:0] RA;
  logic [ADDR_WIDTH-1:0] RB;
  logic [ADDR_WIDTH-1:0] RW;
  logic                  sig_enable_write;
  logic [DATA_WIDTH-1:0] BusW;
  logic [DATA_WIDTH-1:0] BusA;
  logic [DATA_WIDTH-1:0] BusB;

  // Datapath side: supplies addresses and write data, consumes read data
  modport master (
    output RA, RB, RW, sig_enable_write, BusW,
    input  BusA, BusB
  );

  // Register file side
  modport slave (
    input  RA, RB, RW, sig_enable_write, BusW,
    output BusA, BusB
  );

endinterface

// File: rtl/register_file_read_port.sv
// One asynchronous read port: combinational mux over the register array with zero-register masking.
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = REG_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] regs_i,
  input  logic [ADDR_WIDTH-1:0]                      addr_i,
  output logic [DATA_WIDTH-1:0]                      data_o
);

  // Select the addressed register; address 0 reads as zero when the zero register is enabled
  always_comb begin
    data_o = regs_i[addr_i];
    if (ZERO_REG && (addr_i == '0)) begin
      data_o = '0;
    end
  end

endmodule

// File: rtl/register_file.sv
// General-purpose register file: 2**ADDR_WIDTH x DATA_WIDTH flops, two async read ports, one sync write port.
module register_file
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = REG_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  register_file_if.slave  rf
);

  localparam int unsigned NREGS = 2**ADDR_WIDTH;

  logic [NREGS-1:0][DATA_WIDTH-1:0] mem_q;
  logic [NREGS-1:0][DATA_WIDTH-1:0] mem_d;
  logic                             wr_en;
  logic [DATA_WIDTH-1:0]            bus_a;
  logic [DATA_WIDTH-1:0]            bus_b;

  // Qualify the write: writes to the hardwired zero register are dropped
  always_comb begin
    wr_en = rf.sig_enable_write;
    if (ZERO_REG && (rf.RW == '0)) begin
      wr_en = 1'b0;
    end
  end

  // Next-state array: only the addressed register changes on an enabled write
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[rf.RW] = rf.BusW;
    end
  end

  // Register array update; reset clears everything and overrides a same-cycle write
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Reads come straight from the flops, so a write becomes visible one edge later (no bypass)
  register_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_read_a (
    .regs_i (mem_q),
    .addr_i (rf.RA),
    .data_o (bus_a)
  );

  register_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_read_b (
    .regs_i (mem_q),
    .addr_i (rf.RB),
    .data_o (bus_b)
  );

  assign rf.BusA = bus_a;
  assign rf.BusB = bus_b;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file with a reference model and an expected-value queue.
module tb_register_file;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  register_file #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .ZERO_REG   (1'b1)
  ) dut (
    .clock (clk),
    .reset (rst),
    .rf    (bus.slave)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t         sbq[$];
  logic [31:0] model [32];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : model[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic check_next(input logic [31:0] obs);
    sb_t e;
    n_checks++;
    if (sbq.size() == 0) begin
      $error("FAIL sb_empty: observed %h required a queued expectation", obs);
      return;
    end
    e = sbq.pop_front();
    assert (obs === e.exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
  endtask

  // Drive a read pair, queue model expectations, then compare shortly after
  task automatic read_pair(input logic [4:0] ra, input logic [4:0] rb, input string tag);
    bus.RA = ra;
    bus.RB = rb;
    push_exp({tag, "_A"}, model_rd(ra));
    push_exp({tag, "_B"}, model_rd(rb));
    #1;
    check_next(bus.BusA);
    check_next(bus.BusB);
  endtask

  // One enabled write across one rising edge
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    bus.RW = a;
    bus.BusW = d;
    bus.sig_enable_write = 1'b1;
    @(posedge clk);
    #1;
    bus.sig_enable_write = 1'b0;
    if (a != 5'd0) model[a] = d;
  endtask

  initial begin
    rst = 1'b1;
    bus.RA = '0;
    bus.RB = '0;
    bus.RW = '0;
    bus.BusW = '0;
    bus.sig_enable_write = 1'b0;
    model_clear();

    // 1. Reset
    @(posedge clk);
    #1;
    rst = 1'b0;
    read_pair(5'd1, 5'd31, "reset");

    // 2. Basic write/read on consecutive edges
    do_write(5'd1, 32'd16);
    do_write(5'd2, 32'd32);
    read_pair(5'd1, 5'd2, "basic");

    // 3. Collision: old value before the edge, new value after
    bus.RA = 5'd1;
    bus.RB = 5'd2;
    bus.RW = 5'd2;
    bus.BusW = 32'd64;
    bus.sig_enable_write = 1'b1;
    push_exp("coll_pre_A", 32'd16);
    push_exp("coll_pre_B", 32'd32);
    #1;
    check_next(bus.BusA);
    check_next(bus.BusB);
    @(posedge clk);
    #1;
    bus.sig_enable_write = 1'b0;
    model[2] = 32'd64;
    read_pair(5'd1, 5'd2, "coll_post");

    // 4. Write disabled for two edges
    bus.RW = 5'd2;
    bus.BusW = 32'd128;
    bus.sig_enable_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    read_pair(5'd1, 5'd2, "wr_dis");

    // 5. Zero register and top index
    do_write(5'd0, 32'hDEAD_BEEF);
    read_pair(5'd0, 5'd0, "zero");
    do_write(5'd31, 32'hFFFF_FFFF);
    read_pair(5'd0, 5'd31, "r31");

    // 6. Full sweep
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i * 3 + 1));
    for (int i = 0; i < 32; i++) read_pair(5'(i), 5'(31 - i), $sformatf("sweep%0d", i));

    // Refill part way, then reset together with an enabled write
    for (int i = 1; i < 16; i++) do_write(5'(i), 32'(i * 5 + 7));
    read_pair(5'd7, 5'd20, "refill");
    bus.RW = 5'd16;
    bus.BusW = 32'hA5A5_A5A5;
    bus.sig_enable_write = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.sig_enable_write = 1'b0;
    model_clear();
    for (int i = 0; i < 32; i++) read_pair(5'(i), 5'(31 - i), $sformatf("rst_sweep%0d", i));

    // Writes work again after reset; RA == RB returns the same value
    do_write(5'd5, 32'h0000_0055);
    read_pair(5'd5, 5'd5, "post_rst");

    if (sbq.size() != 0) begin
      n_checks++;
      $error("FAIL sb_leftover: observed %0d entries expected 0", sbq.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
